uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver. Consumes the 16x oversampling strobe rxclk_en from baud_rate_gen.
//  - Synchronises the asynchronous serial input, validates the start bit at mid-bit and
//    samples each data and stop bit at its centre.
//  - Presents each received byte with a sticky ready flag, plus framing and overrun flags.
//  - Sits between the board RX pin and the host-side logic, alongside the transmitter.
// PARAMETERS
//  - DATA_BITS   8   data bits per frame, sent LSB first.
//  - OVERSAMPLE  16  rxclk_en strobes per bit. Must be even and >= 4.
// PORTS
//  - clk_100m   in   1          system clock. Sole clock; every flop uses its rising edge.
//  - rst_n      in   1          reset, asynchronous, active-low.
//  - rxclk_en   in   1          one-cycle strobe at OVERSAMPLE x baud.
//  - rx         in   1          serial line. Idles high. Asynchronous to clk_100m.
//  - rdy_clr    in   1          one-cycle request to clear rdy and overrun.
//  - data       out  DATA_BITS  last good byte received.
//  - rdy        out  1          byte available. Sticky.
//  - frame_err  out  1          stop bit sampled low. Sticky.
//  - overrun    out  1          a new byte completed while rdy was already 1. Sticky.
// BEHAVIOUR
//  - Reset values: data=0, rdy=0, frame_err=0, overrun=0, state=IDLE, counters=0, sync flops=1.
//    Reset asserted mid-frame discards the frame at once; no flag is set.
//  - rx passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s only.
//  - State and counters advance only on cycles where rxclk_en=1, except the rdy_clr handling.
//  - IDLE: rx_s=0 on a strobe -> START, with sample_cnt=0.
//  - START: sample_cnt increments on each strobe.
//    - At sample_cnt = OVERSAMPLE/2-1: rx_s=0 -> DATA, with sample_cnt=0 and bit_idx=0.
//    - At that point, rx_s=1 -> IDLE. This is a glitch; no flag is set.
//  - DATA: at sample_cnt = OVERSAMPLE-1, shreg[bit_idx] <= rx_s and sample_cnt wraps to 0.
//    - bit_idx = DATA_BITS-1 -> STOP; otherwise bit_idx increments.
//  - STOP: the stop bit is sampled at sample_cnt = OVERSAMPLE-1, then -> IDLE.
//    The next start bit is detectable from the following strobe.
//    - Stop bit 1: data <= shreg and rdy <= 1. If rdy was already 1, overrun <= 1.
//    - Stop bit 0: frame_err <= 1. data and rdy are unchanged. The byte is dropped.
//  - Latency: flags and data update on the clk_100m edge after the stop-sample strobe.
//    That is about 9.5 bit times after the start edge, plus 2 synchroniser cycles.
//  - rdy_clr acts on any clk_100m cycle, strobe or not. It clears rdy, overrun and frame_err.
//    - rdy_clr in the same cycle as a good byte completing: the set wins.
//      rdy=1, overrun=0, and data takes the new byte.
//    - rdy_clr in the same cycle as a framing error: rdy=0, frame_err=1.
//  - Counter widths: sample_cnt is $clog2(OVERSAMPLE) bits; bit_idx is $clog2(DATA_BITS) bits.
//    Neither counter wraps past its terminal value.
//  - rx held low indefinitely (break): one frame_err, then IDLE re-detects a start bit
//    every frame; no rdy.
// STRUCTURE
//  - Package uart_pkg holds:
//    - the rx_state_t enum {IDLE, START, DATA, STOP};
//    - the localparams UART_DATA_BITS=8 and UART_OVERSAMPLE=16, shared with the transmitter.
//  - Sub-module sync_2ff: a 1-bit two-flop synchroniser with async active-low reset and a
//    reset value parameter (1 here). It is reused by the transmitter and other pin inputs.
//  - Everything else is one FSM plus a datapath in uart_rx.
// TESTING
//  (bench drives rxclk_en every 4 clk_100m cycles, so one bit = 64 cycles)
//  1. Hold rst_n=0 with rx=1 -> data=0x00 and rdy=frame_err=overrun=0.
//     Then assert rst_n=0 mid data bit 3 -> IDLE, no flags set, and the next frame is received.
//  2. Send 0x55 as an 8N1 frame -> rdy=1 and data=0x55, one cycle after the stop-sample strobe.
//     Then rdy_clr -> rdy=0.
//  3. Pull rx low for 4 strobes then high -> no rdy and state back to IDLE.
//     Then send 0xA3 -> data=0xA3 and rdy=1.
//  4. Send 0xFF with the stop bit driven 0 -> frame_err=1, rdy=0, data keeps its prior value.
//  5. Send 0x12 then 0x34 back-to-back without rdy_clr -> data=0x34, rdy=1, overrun=1.
//     Then rdy_clr -> rdy=0 and overrun=0.
//  6. Pulse rdy_clr in the exact cycle 0x7E completes -> rdy=1, data=0x7E, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame parameters and receiver state encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling each bit at its centre from a 16x oversampling strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] CNT_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] CNT_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);

  rx_state_t state_q, state_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic rdy_q, rdy_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rx_s, good, bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk_100m),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d = shreg_q;
    good = 1'b0;
    bad = 1'b0;
    if (rxclk_en) begin
      case (state_q)
        IDLE: begin
          state_d = rx_s ? IDLE : START;
          sample_cnt_d = '0;
        end
        START: begin
          if (sample_cnt_q == CNT_MID) begin
            state_d = rx_s ? IDLE : DATA;
            sample_cnt_d = '0;
            bit_idx_d = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (sample_cnt_q == CNT_END) begin
            shreg_d[bit_idx_q] = rx_s;
            sample_cnt_d = '0;
            state_d = (bit_idx_q == BIT_END) ? STOP : DATA;
            bit_idx_d = (bit_idx_q == BIT_END) ? bit_idx_q : bit_idx_q + 1'b1;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (sample_cnt_q == CNT_END) begin
            state_d = IDLE;
            sample_cnt_d = '0;
            good = rx_s;
            bad = ~rx_s;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // a completing frame takes priority over a simultaneous clear
    data_d = good ? shreg_q : data_q;
    rdy_d = good | (rdy_q & ~rdy_clr);
    overrun_d = ~rdy_clr & (overrun_q | (good & rdy_q));
    frame_err_d = bad | (frame_err_q & ~rdy_clr);
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      rdy_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      rdy_q <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign data = data_q;
  assign rdy = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame tests for uart_rx at 4 clocks per strobe, 64 clocks per bit
module tb_uart_rx;
  import uart_pkg::*;
  logic clk_100m = 1'b0;
  logic rst_n = 1'b0;
  logic rxclk_en = 1'b0;
  logic rx = 1'b1;
  logic rdy_clr = 1'b0;
  logic [7:0] data;
  logic rdy, frame_err, overrun;
  int checks = 0;
  int failures = 0;

  uart_rx dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .rxclk_en (rxclk_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk_100m = ~clk_100m;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_100m);
      #1;
      rxclk_en = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_100m);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk_100m);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(64);
    end
    rx = stop;
    wait_clks(64);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_100m);
    rdy_clr = 1'b1;
    @(negedge clk_100m);
    rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    rx = 1'b1;
    wait_clks(10);
    checks++;
    if (data !== 8'h00 || rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got data=%h rdy=%b fe=%b ov=%b want 00 0 0 0", data, rdy, frame_err, overrun);
    end
    rst_n = 1'b1;
    wait_clks(64);
    rx = 1'b0;
    wait_clks(64);
    rx = 1'b1;
    wait_clks(192 + 32);
    rst_n = 1'b0;
    wait_clks(3);
    checks++;
    if (dut.state_q !== IDLE || rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset got state=%0d rdy=%b fe=%b ov=%b data=%h want IDLE 0 0 0 00",
               dut.state_q, rdy, frame_err, overrun, data);
    end
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(64);
    send_frame(8'h5A, 1'b1);
    wait_clks(16);
    checks++;
    if (data !== 8'h5A || rdy !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_frame got data=%h rdy=%b fe=%b want 5a 1 0", data, rdy, frame_err);
    end
    pulse_clr();
  endtask

  task automatic test_basic();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge rx);
        for (int i = 0; i < 700 && !seen; i++) begin
          @(posedge clk_100m);
          n++;
          @(negedge clk_100m);
          seen = rdy;
        end
      end
    join
    checks++;
    if (!seen || n < 611 || n > 614) begin
      failures++;
      $display("FAIL rdy_latency got seen=%b cycles=%0d want 1 in 611..614", seen, n);
    end
    checks++;
    if (data !== 8'h55 || rdy !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL byte_55 got data=%h rdy=%b ov=%b want 55 1 0", data, rdy, overrun);
    end
    pulse_clr();
    checks++;
    if (rdy !== 1'b0 || data !== 8'h55) begin
      failures++;
      $display("FAIL clr_55 got rdy=%b data=%h want 0 55", rdy, data);
    end
  endtask

  task automatic test_glitch();
    wait_clks(20);
    rx = 1'b0;
    wait_clks(16);
    rx = 1'b1;
    wait_clks(64);
    checks++;
    if (dut.state_q !== IDLE || rdy !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch got state=%0d rdy=%b fe=%b want IDLE 0 0", dut.state_q, rdy, frame_err);
    end
    send_frame(8'hA3, 1'b1);
    wait_clks(16);
    checks++;
    if (data !== 8'hA3 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL byte_a3 got data=%h rdy=%b want a3 1", data, rdy);
    end
    pulse_clr();
  endtask

  task automatic test_frame_err();
    send_frame(8'hFF, 1'b0);
    wait_clks(128);
    checks++;
    if (frame_err !== 1'b1 || rdy !== 1'b0 || data !== 8'hA3 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL frame_err got fe=%b rdy=%b data=%h ov=%b want 1 0 a3 0", frame_err, rdy, data, overrun);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL fe_idle got state=%0d want IDLE", dut.state_q);
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL fe_clear got fe=%b want 0", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_clks(16);
    checks++;
    if (data !== 8'h34 || rdy !== 1'b1 || overrun !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL overrun got data=%h rdy=%b ov=%b fe=%b want 34 1 1 0", data, rdy, overrun, frame_err);
    end
    pulse_clr();
    checks++;
    if (rdy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr got rdy=%b ov=%b want 0 0", rdy, overrun);
    end
  endtask

  task automatic test_clr_collide();
    bit hit;
    hit = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_clks(16);
    checks++;
    if (data !== 8'h11 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL byte_11 got data=%h rdy=%b want 11 1", data, rdy);
    end
    fork
      send_frame(8'h7E, 1'b1);
      begin
        for (int i = 0; i < 800 && !hit; i++) begin
          @(negedge clk_100m);
          if (dut.state_q == STOP && rxclk_en && dut.sample_cnt_q == 4'hF) begin
            rdy_clr = 1'b1;
            hit = 1'b1;
          end
        end
        @(negedge clk_100m);
        rdy_clr = 1'b0;
      end
    join
    wait_clks(4);
    checks++;
    if (!hit || rdy !== 1'b1 || data !== 8'h7E || overrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_collide got hit=%b rdy=%b data=%h ov=%b want 1 1 7e 0", hit, rdy, data, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_clr_collide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
